// File: rtl/change_return_dispenser_if.sv
// Request/response bundle between the vending controller and the change dispenser.
// The master issues vend requests with the captured credit. The slave reports its
// progress and drives the solenoid and coin-eject lines.
interface change_return_dispenser_if;
  logic       vend_req;
  logic [2:0] credit_units;
  logic       busy;
  logic       paper_out;
  logic       coin5_out;
  logic [2:0] change_left;
  logic       vend_done;
  logic       error;

  modport master (
    output vend_req, credit_units,
    input  busy, paper_out, coin5_out, change_left, vend_done, error
  );

  modport slave (
    input  vend_req, credit_units,
    output busy, paper_out, coin5_out, change_left, vend_done, error
  );
endinterface

// File: rtl/change_return_dispenser.sv
// Change return dispenser.
// On a valid vend request it captures the credit. It then drives the newspaper
// solenoid for a fixed time. Finally it returns any credit above the price as
// timed 5-rupee eject pulses, separated by low gaps. Invalid requests get a
// one-cycle error pulse. Every drive output is a Moore decode of the state
// register, so the outputs cannot glitch.
module change_return_dispenser #(
  parameter int PRICE_UNITS  = 3,
  parameter int PAPER_CYCLES = 200_000_000,
  parameter int PULSE_CYCLES = 50_000_000,
  parameter int GAP_CYCLES   = 50_000_000,
  parameter int CNT_W        = 28
) (
  input  logic                       clk,
  input  logic                       reset,
  change_return_dispenser_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PAPER = 3'd1,
    PULSE = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] PAPER_LAST = CNT_W'(PAPER_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [2:0]       PRICE      = 3'(PRICE_UNITS);
  localparam logic [2:0]       MAX_CREDIT = 3'd5;

  state_t           state, state_next;
  logic [CNT_W-1:0] timer, timer_next;
  logic [2:0]       change_left_q, change_left_next;
  logic             error_q, error_next;
  logic             credit_ok;

  assign credit_ok = (bus.credit_units >= PRICE) && (bus.credit_units <= MAX_CREDIT);

  // State, timer, remaining change and error pulse registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      change_left_q <= 3'd0;
      error_q       <= 1'b0;
    end else begin
      state         <= state_next;
      timer         <= timer_next;
      change_left_q <= change_left_next;
      error_q       <= error_next;
    end
  end

  // Next-state logic: the timer counts 0..N-1 in each timed state and returns to zero on every exit
  always_comb begin
    state_next       = state;
    timer_next       = '0;
    change_left_next = change_left_q;
    error_next       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.vend_req) begin
          if (credit_ok) begin
            state_next       = PAPER;
            change_left_next = bus.credit_units - PRICE;
          end else begin
            error_next = 1'b1;
          end
        end
      end
      PAPER: begin
        if (timer == PAPER_LAST) begin
          state_next = (change_left_q == 3'd0) ? DONE : PULSE;
        end else begin
          timer_next = timer + CNT_W'(1);
        end
      end
      PULSE: begin
        if (timer == PULSE_LAST) begin
          if (change_left_q != 3'd0) begin
            change_left_next = change_left_q - 3'd1;
          end
          state_next = (change_left_q <= 3'd1) ? DONE : GAP;
        end else begin
          timer_next = timer + CNT_W'(1);
        end
      end
      GAP: begin
        if (timer == GAP_LAST) begin
          state_next = PULSE;
        end else begin
          timer_next = timer + CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy        = (state != IDLE);
  assign bus.paper_out   = (state == PAPER);
  assign bus.coin5_out   = (state == PULSE);
  assign bus.vend_done   = (state == DONE);
  assign bus.change_left = change_left_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_change_return_dispenser.sv
// Directed testbench for change_return_dispenser using short timer values.
// Cycle 0 of each case is the cycle in which vend_req is driven. Outputs are
// sampled on the falling edge and compared against hand-derived cycle windows.
module tb_change_return_dispenser;

  logic clk;
  logic reset;
  int   total_checks;
  int   bad_checks;

  change_return_dispenser_if bus();

  change_return_dispenser #(
    .PRICE_UNITS (3),
    .PAPER_CYCLES(4),
    .PULSE_CYCLES(2),
    .GAP_CYCLES  (3),
    .CNT_W       (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] observed;
  assign observed = {bus.busy, bus.paper_out, bus.coin5_out, bus.change_left,
                     bus.vend_done, bus.error};

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one packed output vector {busy,paper,coin,change[2:0],done,error}
  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] want);
    total_checks++;
    if (got !== want) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %b expected %b", tag, got, want);
    end
  endtask

  function automatic logic inr(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Expected outputs per case and cycle, written straight from the timing windows
  function automatic logic [7:0] expVec(input int id, input int c);
    logic       b, p, k, d, e;
    logic [2:0] ch;
    b = 1'b0; p = 1'b0; k = 1'b0; d = 1'b0; e = 1'b0; ch = 3'd0;
    case (id)
      1: begin
        b = inr(c, 1, 5); p = inr(c, 1, 4); d = (c == 5);
      end
      2: begin
        b  = inr(c, 1, 12); p = inr(c, 1, 4);
        k  = inr(c, 5, 6) || inr(c, 10, 11);
        ch = inr(c, 1, 6) ? 3'd2 : (inr(c, 7, 11) ? 3'd1 : 3'd0);
        d  = (c == 12);
      end
      3, 7: begin
        e = (c == 1);
      end
      4: begin
        b  = inr(c, 1, 7); p = inr(c, 1, 4); k = inr(c, 5, 6);
        ch = inr(c, 1, 6) ? 3'd1 : 3'd0;
        d  = (c == 7);
      end
      5: begin
        if (c <= 6) begin
          b = inr(c, 1, 6); p = inr(c, 1, 4); k = inr(c, 5, 6);
          ch = inr(c, 1, 6) ? 3'd2 : 3'd0;
        end else begin
          b = inr(c, 9, 13); p = inr(c, 9, 12); d = (c == 13);
        end
      end
      6: begin
        b = inr(c, 1, 5) || inr(c, 7, 11);
        p = inr(c, 1, 4) || inr(c, 7, 10);
        d = (c == 5) || (c == 11);
      end
      default: ;
    endcase
    return {b, p, k, ch, d, e};
  endfunction

  // Drives the inputs for cycle c of case id
  task automatic applyStimulus(input int id, input int c);
    bus.vend_req     = 1'b0;
    bus.credit_units = 3'd0;
    reset            = 1'b0;
    case (id)
      1: if (c == 0) begin bus.vend_req = 1'b1; bus.credit_units = 3'd3; end
      2: if (c == 0) begin bus.vend_req = 1'b1; bus.credit_units = 3'd5; end
      3: if (c == 0) begin bus.vend_req = 1'b1; bus.credit_units = 3'd2; end
      7: if (c == 0) begin bus.vend_req = 1'b1; bus.credit_units = 3'd6; end
      4: begin
        if (c == 0) begin bus.vend_req = 1'b1; bus.credit_units = 3'd4; end
        if (c == 3) begin bus.vend_req = 1'b1; bus.credit_units = 3'd5; end
      end
      5: begin
        if (c == 0) begin bus.vend_req = 1'b1; bus.credit_units = 3'd5; end
        if (c == 6) reset = 1'b1;
        if (c == 8) begin bus.vend_req = 1'b1; bus.credit_units = 3'd3; end
      end
      6: begin
        if (c == 0 || c == 5 || c == 6) begin
          bus.vend_req = 1'b1; bus.credit_units = 3'd3;
        end
      end
      default: ;
    endcase
  endtask

  // Runs one directed case cycle by cycle, checking each cycle after the request
  task automatic runCase(input int id, input int len);
    for (int c = 0; c <= len; c++) begin
      if (c > 0) checkOutput($sformatf("case%0d_c%0d", id, c), observed, expVec(id, c));
      applyStimulus(id, c);
      @(negedge clk);
    end
    applyStimulus(0, 0);
  endtask

  // Main sequence: reset checks, then each directed case
  initial begin
    total_checks     = 0;
    bad_checks       = 0;
    reset            = 1'b1;
    bus.vend_req     = 1'b0;
    bus.credit_units = 3'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", observed, 8'b0);

    bus.vend_req     = 1'b1;
    bus.credit_units = 3'd3;
    @(negedge clk);
    checkOutput("req_during_reset", observed, 8'b0);
    bus.vend_req     = 1'b0;
    bus.credit_units = 3'd0;
    reset            = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_reset", observed, 8'b0);
    @(negedge clk);

    $display("[TB] case 1: exact price");
    runCase(1, 7);
    $display("[TB] case 2: two coins of change");
    runCase(2, 14);
    $display("[TB] case 3: credit too low / too high");
    runCase(3, 4);
    runCase(7, 4);
    $display("[TB] case 4: request while busy");
    runCase(4, 9);
    $display("[TB] case 5: reset mid-transaction");
    runCase(5, 15);
    $display("[TB] case 6: back-to-back requests");
    runCase(6, 13);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
